// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: command FIFO -> registered issue stage -> external ALU ->
// response FIFO. Issue is credit-gated so a registered ALU result always has
// a response slot waiting for it, whatever the consumer does.
// Optional build macro: ALU_ISSUER_STATS_EN enables the saturating
// back-pressure counter on stat_stall_cnt; otherwise the port is tied to 0.
module alu_cmd_issuer #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_opcode,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_tag,
  output logic [1:0] alu_opcode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [4:0] alu_c,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_c,
  output logic [3:0] rsp_tag,
  output logic [7:0] stat_stall_cnt
);

  localparam int CAW   = $clog2(CMD_DEPTH);
  localparam int CPW   = CAW + 1;
  localparam int RAW   = $clog2(RSP_DEPTH);
  localparam int RPW   = RAW + 1;
  localparam int SUM_W = RAW + 2;

  typedef struct packed {
    logic [1:0] opcode;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] tag;
  } cmd_t;

  typedef struct packed {
    logic [4:0] c;
    logic [3:0] tag;
  } rsp_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t           cmd_mem_q [CMD_DEPTH];
  logic [CPW-1:0] cmd_wptr_q, cmd_wptr_d;
  logic [CPW-1:0] cmd_rptr_q, cmd_rptr_d;
  logic           cmd_empty;
  logic           cmd_full;
  logic           cmd_push;
  cmd_t           cmd_in;
  cmd_t           cmd_head;

  assign cmd_empty = (cmd_wptr_q == cmd_rptr_q);
  assign cmd_full  = (cmd_wptr_q[CAW] != cmd_rptr_q[CAW]) &&
                     (cmd_wptr_q[CAW-1:0] == cmd_rptr_q[CAW-1:0]);

  // Ready depends only on stored occupancy; held low while reset is asserted.
  assign cmd_ready = reset & ~cmd_full;
  assign cmd_push  = cmd_valid & cmd_ready;
  assign cmd_in    = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, tag: cmd_tag};
  assign cmd_head  = cmd_mem_q[cmd_rptr_q[CAW-1:0]];

  // Command storage write port (contents need no reset; pointers gate use).
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_mem_q[cmd_wptr_q[CAW-1:0]] <= cmd_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue stage and credit check
  // ---------------------------------------------------------------------------
  logic             issue_vld_q, issue_vld_d;
  logic [1:0]       alu_opcode_q, alu_opcode_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic [3:0]       issue_tag_q, issue_tag_d;
  logic             c_vld_q;
  logic [3:0]       c_tag_q;
  logic [RPW-1:0]   rsp_count;
  logic [SUM_W-1:0] credit_sum;
  logic             credit_ok;
  logic             issue_go;

  // Slots already claimed: entry in issue, entry in ALU, entries buffered,
  // plus the one about to be issued. A same-cycle response pop is not credited.
  assign credit_sum = SUM_W'(rsp_count) + SUM_W'(issue_vld_q) +
                      SUM_W'(c_vld_q) + SUM_W'(1);
  assign credit_ok  = (credit_sum <= SUM_W'(RSP_DEPTH));
  assign issue_go   = ~cmd_empty & credit_ok;

  // Command pointer next-state.
  always_comb begin
    cmd_wptr_d = cmd_wptr_q;
    cmd_rptr_d = cmd_rptr_q;
    if (cmd_push) begin
      cmd_wptr_d = cmd_wptr_q + CPW'(1);
    end
    if (issue_go) begin
      cmd_rptr_d = cmd_rptr_q + CPW'(1);
    end
  end

  // Command pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
    end else begin
      cmd_wptr_q <= cmd_wptr_d;
      cmd_rptr_q <= cmd_rptr_d;
    end
  end

  // Issue-stage next-state: ALU operands hold their last value when idle.
  always_comb begin
    issue_vld_d  = 1'b0;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    issue_tag_d  = issue_tag_q;
    if (issue_go) begin
      issue_vld_d  = 1'b1;
      alu_opcode_d = cmd_head.opcode;
      alu_a_d      = cmd_head.a;
      alu_b_d      = cmd_head.b;
      issue_tag_d  = cmd_head.tag;
    end
  end

  // Issue-stage registers driving the ALU inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_vld_q  <= 1'b0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      issue_tag_q  <= '0;
    end else begin
      issue_vld_q  <= issue_vld_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      issue_tag_q  <= issue_tag_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

  // ALU stage tracker: follows the issue stage by one cycle, matching the
  // ALU's own output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_vld_q <= 1'b0;
      c_tag_q <= '0;
    end else begin
      c_vld_q <= issue_vld_q;
      c_tag_q <= issue_tag_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  rsp_t           rsp_mem_q [RSP_DEPTH];
  logic [RPW-1:0] rsp_wptr_q, rsp_wptr_d;
  logic [RPW-1:0] rsp_rptr_q, rsp_rptr_d;
  logic           rsp_empty;
  logic           rsp_push;
  logic           rsp_pop;
  rsp_t           rsp_head;

  assign rsp_count = rsp_wptr_q - rsp_rptr_q;
  assign rsp_empty = (rsp_wptr_q == rsp_rptr_q);
  assign rsp_push  = c_vld_q;
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign rsp_head  = rsp_mem_q[rsp_rptr_q[RAW-1:0]];

  // Response storage write port; space is guaranteed by the issue credit.
  always_ff @(posedge clk) begin
    if (rsp_push) begin
      rsp_mem_q[rsp_wptr_q[RAW-1:0]] <= '{c: alu_c, tag: c_tag_q};
    end
  end

  // Response pointer next-state.
  always_comb begin
    rsp_wptr_d = rsp_wptr_q;
    rsp_rptr_d = rsp_rptr_q;
    if (rsp_push) begin
      rsp_wptr_d = rsp_wptr_q + RPW'(1);
    end
    if (rsp_pop) begin
      rsp_rptr_d = rsp_rptr_q + RPW'(1);
    end
  end

  // Response pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_wptr_q <= '0;
      rsp_rptr_q <= '0;
    end else begin
      rsp_wptr_q <= rsp_wptr_d;
      rsp_rptr_q <= rsp_rptr_d;
    end
  end

  // Head fields are forced to zero when empty so reset shows clean outputs
  // without resetting the storage array.
  assign rsp_valid = ~rsp_empty;
  assign rsp_c     = rsp_empty ? '0 : rsp_head.c;
  assign rsp_tag   = rsp_empty ? '0 : rsp_head.tag;

  // ---------------------------------------------------------------------------
  // Back-pressure statistics
  // ---------------------------------------------------------------------------
`ifdef ALU_ISSUER_STATS_EN
  logic [7:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where a response is held by the consumer.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rsp_valid && !rsp_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  // Stall counter register; cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
`else
  assign stat_stall_cnt = '0;
`endif

endmodule
